ex_cmm_frame_sched: RTL



---
 rtl/ex_cmm_pkg.sv | 23 ++
 rtl/rr_arb16.sv | 27 ++
 rtl/ex_cmm_frame_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ex_cmm_pkg.sv
// Shared definitions for the single-extension box configuration channel path:
// frame delimiter bit positions, error codes and frame scheduler state encodings.
package ex_cmm_pkg;

    localparam int SOP_BIT = 17;
    localparam int EOP_BIT = 16;

    localparam logic [1:0] ERR_NOSOP = 2'b01;
    localparam logic [1:0] ERR_OVLEN = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;

    // One-hot read strobe for a 4-bit channel index.
    function automatic logic [15:0] chnOneHot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_arb16.sv
// Combinational 16-way round-robin pick: the first requester found searching
// upward from last+1, wrapping 15 -> 0, with 'last' itself lowest priority.
module rr_arb16
    import ex_cmm_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  last,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld
);

    // Scan from the farthest offset down so the nearest requester after 'last' overrides.
    always_comb begin
        logic [3:0] w_cand;
        gnt_idx = 4'd0;
        gnt_vld = 1'b0;
        w_cand  = 4'd0;
        for (int k = 16; k >= 1; k--) begin
            w_cand = last + 4'(k);
            if (req[w_cand]) begin
                gnt_idx = w_cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_cmm_frame_sched.sv
// Frame-granular round-robin read scheduler: pulls whole frames from the 16
// per-slot channel buffers into the shared downstream FIFO, one channel at a
// time, with stop-and-wait reads, frame-length policing and error strobes.
module ex_cmm_frame_sched
    import ex_cmm_pkg::*;
#(
    parameter int         CHN_NUM     = 16,
    parameter int         DATA_W      = 18,
    parameter int         RD_LAT      = 2,
    parameter logic [9:0] MAX_FRM_LEN = 10'd512
)(
    input  logic               clk_12_5m,
    input  logic               rst_12_5m,
    input  logic               sched_en,
    input  logic [CHN_NUM-1:0] chn_mask,
    input  logic [CHN_NUM-1:0] chn_empty,
    output logic [CHN_NUM-1:0] chn_rden,
    input  logic [CHN_NUM-1:0] chn_dval,
    input  logic [DATA_W-1:0]  chn_data,
    input  logic               out_afull,
    output logic               out_wren,
    output logic [DATA_W-1:0]  out_wrdata,
    output logic [3:0]         cur_chn,
    output logic               busy,
    output logic               err_pulse,
    output logic [1:0]         err_code,
    output logic [3:0]         err_chn
);

    // A read is given up once this many WAIT cycles pass without its data.
    localparam logic [2:0] TMO_CNT   = 3'(RD_LAT + 1);
    localparam logic [9:0] LAST_WORD = MAX_FRM_LEN - 10'd1;

    logic [2:0]         r_state;
    logic [3:0]         r_lastGrant;
    logic [3:0]         r_curChn;
    logic               r_busy;
    logic [9:0]         r_wordCnt;
    logic [2:0]         r_waitCnt;
    logic [CHN_NUM-1:0] r_rden;
    logic               r_wren;
    logic [DATA_W-1:0]  r_wrdata;
    logic               r_errPulse;
    logic [1:0]         r_errCode;
    logic [3:0]         r_errChn;

    logic [CHN_NUM-1:0] w_elig;
    logic [3:0]         w_gntIdx;
    logic               w_gntVld;
    logic [DATA_W-1:0]  w_forcedEop;

    assign w_elig      = ~chn_empty & ~chn_mask;
    assign w_forcedEop = {chn_data[DATA_W-1:EOP_BIT+1], 1'b1, chn_data[EOP_BIT-1:0]};

    rr_arb16 u_arb (
        .req     (w_elig),
        .last    (r_lastGrant),
        .gnt_idx (w_gntIdx),
        .gnt_vld (w_gntVld)
    );

    // Scheduler FSM plus all registered outputs; strobes default low every cycle.
    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= 4'd15;
            r_curChn    <= 4'd0;
            r_busy      <= 1'b0;
            r_wordCnt   <= 10'd0;
            r_waitCnt   <= 3'd0;
            r_rden      <= '0;
            r_wren      <= 1'b0;
            r_wrdata    <= '0;
            r_errPulse  <= 1'b0;
            r_errCode   <= 2'b00;
            r_errChn    <= 4'd0;
        end else begin
            r_rden     <= '0;
            r_wren     <= 1'b0;
            r_errPulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sched_en && (|w_elig)) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_gntVld) begin
                        r_curChn  <= w_gntIdx;
                        r_busy    <= 1'b1;
                        r_wordCnt <= 10'd0;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!chn_empty[r_curChn] && !out_afull) begin
                        r_rden    <= chnOneHot(r_curChn);
                        r_waitCnt <= 3'd0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (chn_dval[r_curChn]) begin
                        if ((r_wordCnt == 10'd0) && !chn_data[SOP_BIT]) begin
                            r_errPulse <= 1'b1;
                            r_errCode  <= ERR_NOSOP;
                            r_errChn   <= r_curChn;
                            r_state    <= ST_CLOSE;
                        end else begin
                            r_wren    <= 1'b1;
                            r_wrdata  <= chn_data;
                            r_wordCnt <= r_wordCnt + 10'd1;
                            if (chn_data[EOP_BIT]) begin
                                r_state <= ST_CLOSE;
                            end else if (r_wordCnt == LAST_WORD) begin
                                r_wrdata   <= w_forcedEop;
                                r_errPulse <= 1'b1;
                                r_errCode  <= ERR_OVLEN;
                                r_errChn   <= r_curChn;
                                r_state    <= ST_CLOSE;
                            end else begin
                                r_state <= ST_ISSUE;
                            end
                        end
                    end else if (r_waitCnt == TMO_CNT) begin
                        r_errPulse <= 1'b1;
                        r_errCode  <= ERR_TMO;
                        r_errChn   <= r_curChn;
                        r_state    <= ST_CLOSE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 3'd1;
                    end
                end
                ST_CLOSE: begin
                    r_lastGrant <= r_curChn;
                    r_busy      <= 1'b0;
                    r_state     <= sched_en ? ST_ARB : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign chn_rden   = r_rden;
    assign out_wren   = r_wren;
    assign out_wrdata = r_wrdata;
    assign cur_chn    = r_curChn;
    assign busy       = r_busy;
    assign err_pulse  = r_errPulse;
    assign err_code   = r_errCode;
    assign err_chn    = r_errChn;

endmodule
